// File: rtl/contador_mod10.sv
// contador_mod10 -- BCD (mod-10) down-counter digit with asynchronous clear and
// asynchronous parallel load. Intended to be cascaded: tc is the borrow-out to
// the next digit.
//
// Build option: define CONTADOR_LOAD_CLAMP_EN to load illegal data (10..15) as 9.
// Without it, illegal data loads as data-10.
//
// While loadn is low, ones follows the legalised data directly. The rising
// edge of loadn snapshots the legalised data into ld_val_q. Until the next
// clock edge folds that snapshot into the counter register, the snapshot
// supplies the count.
module contador_mod10 (
    input  logic       clock,
    input  logic       clrn,
    input  logic       loadn,
    input  logic       enable,
    input  logic [3:0] data,
    output logic [3:0] ones,
    output logic       tc,
    output logic       zero
);

    // Map any 4-bit preset onto a legal BCD digit.
    function automatic logic [3:0] legalize(input logic [3:0] v);
`ifdef CONTADOR_LOAD_CLAMP_EN
        return (v > 4'd9) ? 4'd9 : v;
`else
        return (v > 4'd9) ? (v - 4'd10) : v;
`endif
    endfunction

    logic [3:0] load_val;   // legalised preset
    logic [3:0] cnt_q;      // counter register, clock domain
    logic [3:0] cnt_d;
    logic [3:0] ld_val_q;   // preset captured when loadn is released
    logic       ld_tog_q;   // flips on every loadn release
    logic       ack_q;      // clock-side copy of ld_tog_q
    logic       pend;       // a release happened since the last clock edge
    logic [3:0] cur;        // logical count while loadn is high

    assign load_val = legalize(data);
    assign pend     = ld_tog_q ^ ack_q;
    assign cur      = pend ? ld_val_q : cnt_q;

    // Snapshot the preset on loadn release.
    // A pulse that falls between two clock edges therefore still takes effect.
    always_ff @(posedge loadn or negedge clrn) begin
        if (!clrn) begin
            ld_val_q <= 4'd0;
            ld_tog_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so that every
            // flop samples pre-edge values regardless of block evaluation order.
            ld_val_q <= load_val;
            ld_tog_q <= ~ld_tog_q;
        end
    end

    // Next count: load has priority, then decrement with 0->9 wrap, else hold.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cur;
        if (!loadn) begin
            cnt_d = load_val;
        end else if (enable) begin
            cnt_d = (cur == 4'd0) ? 4'd9 : (cur - 4'd1);
        end
    end

    // Counter register with asynchronous clear.
    // This register also acknowledges any pending load snapshot.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= 4'd0;
            ack_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ack_q <= ld_tog_q;
        end
    end

    // Output count: clear overrides load, and a held load is transparent to data.
    always_comb begin
        ones = cur;
        if (!clrn) begin
            ones = 4'd0;
        end else if (!loadn) begin
            ones = load_val;
        end
    end

    // Terminal-count and zero decodes of the visible count.
    always_comb begin
        zero = (ones == 4'd0);
        tc   = zero & enable;
    end

endmodule

// File: tb/tb_contador_mod10.sv
// Self-checking bench for contador_mod10.
// The directed steps come first. A randomized phase follows and is checked
// against a digit model that uses plain arithmetic.
module tb_contador_mod10;

    logic       clock = 1'b0;
    logic       clrn;
    logic       loadn;
    logic       enable;
    logic [3:0] data;
    logic [3:0] ones;
    logic       tc;
    logic       zero;

    int checks = 0;
    int errors = 0;
    int exp_ones;
    bit ld_held;

    contador_mod10 dut (
        .clock  (clock),
        .clrn   (clrn),
        .loadn  (loadn),
        .enable (enable),
        .data   (data),
        .ones   (ones),
        .tc     (tc),
        .zero   (zero)
    );

    always #5 clock = ~clock;

    // Value a preset should produce after legalisation.
    function automatic int legal(input int d);
`ifdef CONTADOR_LOAD_CLAMP_EN
        return (d > 9) ? 9 : d;
`else
        return d % 10;
`endif
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Compare ones, zero and tc against the model value and the driven enable.
    task automatic check_all(input string tag);
        check({tag, "_ones"}, ones, 4'(exp_ones));
        check({tag, "_zero"}, {3'b000, zero}, {3'b000, (exp_ones == 0)});
        check({tag, "_tc"},   {3'b000, tc},   {3'b000, (exp_ones == 0) && (enable == 1'b1)});
    endtask

    initial begin
        int d;
        int mode;

        clrn = 1'b0; loadn = 1'b1; enable = 1'b1; data = 4'd0;
        exp_ones = 0;
        ld_held = 1'b0;

        // Clear held with the clock running and enable high.
        repeat (3) begin
            @(posedge clock); #1 check_all("reset_run");
        end
        @(negedge clock); enable = 1'b0;
        #1 check_all("reset_en0");

        // Short load pulse between edges.
        @(negedge clock);
        clrn = 1'b1; data = 4'd8;
        #1 loadn = 1'b0; exp_ones = 8;
        #1 check_all("load_async");
        #2 loadn = 1'b1;
        #0.5 check_all("load_release");
        repeat (3) begin
            @(posedge clock); #1 check_all("load_hold");
        end

        // Twelve enabled edges from 8: 7,6,...,0,9,8,7,6.
        @(negedge clock); enable = 1'b1;
        repeat (12) begin
            @(posedge clock); exp_ones = (exp_ones + 9) % 10;
            #1 check_all("count12");
        end
        check("count12_end", ones, 4'd6);

        // Count down to 0 and test the combinational tc.
        repeat (6) begin
            @(posedge clock); exp_ones = (exp_ones + 9) % 10;
            #1 check_all("to_zero");
        end
        @(negedge clock); enable = 1'b0;
        #1 check_all("zero_idle");
        #1 enable = 1'b1;
        #1 check_all("tc_comb");
        @(posedge clock); exp_ones = 9;
        #1 check_all("wrap");

        // Clear between edges while counting at 5.
        repeat (4) begin
            @(posedge clock); exp_ones = (exp_ones + 9) % 10;
            #1 check_all("to_five");
        end
        @(negedge clock);
        #1 clrn = 1'b0; exp_ones = 0;
        #1 check_all("clr_mid");
        #1 clrn = 1'b1;
        #1 check_all("clr_release");
        @(posedge clock); exp_ones = 9;
        #1 check_all("after_clr");

        // Load illegal preset 13.
        @(negedge clock); enable = 1'b0; data = 4'd13;
        #1 loadn = 1'b0; exp_ones = legal(13);
        #1 check_all("illegal13");
        #1 loadn = 1'b1;
        @(posedge clock); #1 check_all("illegal13_hold");

        // Load held across an edge blocks decrement.
        // Counting resumes on the edge after release.
        @(negedge clock); enable = 1'b1; data = 4'd4;
        #1 loadn = 1'b0; exp_ones = 4;
        @(posedge clock); #1 check_all("load_on_edge");
        @(negedge clock); #1 loadn = 1'b1;
        #1 check_all("load_off");
        @(posedge clock); exp_ones = 3;
        #1 check_all("resume");

        // Randomized phase.
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            enable = 1'($urandom_range(0, 1));
            if (ld_held) begin
                d = $urandom_range(0, 15);
                data = 4'(d); exp_ones = legal(d);
                #1 check_all("rnd_follow");
                loadn = 1'b1; ld_held = 1'b0;
                #1 check_all("rnd_release");
            end else begin
                mode = $urandom_range(0, 9);
                if (mode == 0) begin
                    #1 clrn = 1'b0; exp_ones = 0;
                    #1 check_all("rnd_clr");
                    #1 clrn = 1'b1;
                end else if (mode == 1) begin
                    d = $urandom_range(0, 15);
                    data = 4'(d);
                    #1 loadn = 1'b0; exp_ones = legal(d);
                    #1 check_all("rnd_pulse");
                    d = $urandom_range(0, 15);
                    data = 4'(d); exp_ones = legal(d);
                    #1 check_all("rnd_pulse_follow");
                    loadn = 1'b1;
                    #1 check_all("rnd_pulse_rel");
                end else if (mode == 2) begin
                    d = $urandom_range(0, 15);
                    data = 4'(d);
                    #1 loadn = 1'b0; exp_ones = legal(d); ld_held = 1'b1;
                    #1 check_all("rnd_held");
                end
            end
            @(posedge clock);
            if (!ld_held && enable) exp_ones = (exp_ones + 9) % 10;
            #1 check_all("rnd_edge");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
